// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg : shared sizes, state encoding and address helper for the
//                   main-memory arbiter.
// Revision        : 1.0
// ============================================================================
package mem_arbiter_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int MEM_LATENCY = 4;
  localparam int CTR_W       = $clog2(BLOCK_WORDS);

  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_D_FILL  = 2'd1,
    ST_D_WRITE = 2'd2,
    ST_I_FILL  = 2'd3
  } arb_state_e;

  // Byte address of word idx inside the block at base (16-bit words).
  function automatic logic [15:0] word_addr(input logic [15:0]      base,
                                            input logic [CTR_W-1:0] idx);
    return base | {{(16-CTR_W-1){1'b0}}, idx, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_block_fill_ctr.sv
`default_nettype none
// ============================================================================
// mem_arbiter_block_fill_ctr : issue / receive word counters for one block
//                              fill, cleared on each new grant.
// Revision                   : 1.0
// ============================================================================
module mem_arbiter_block_fill_ctr
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             issue_i,
  input  logic             recv_i,
  output logic [CTR_W-1:0] issue_idx_o,
  output logic [CTR_W-1:0] recv_idx_o,
  output logic             issue_busy_o,
  output logic             last_recv_o
);

  localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(BLOCK_WORDS - 1);

  logic [CTR_W-1:0] issue_q, issue_d;
  logic [CTR_W-1:0] recv_q,  recv_d;
  logic             issued_all_q, issued_all_d;

  // The issue counter wraps to 0 after the last word; issued_all keeps it
  // from starting a second pass over the block.
  always_comb begin
    issue_d      = issue_q;
    recv_d       = recv_q;
    issued_all_d = issued_all_q;
    if (clr_i) begin
      issue_d      = '0;
      recv_d       = '0;
      issued_all_d = 1'b0;
    end else begin
      if (issue_i && !issued_all_q) begin
        issue_d = issue_q + CTR_W'(1);
        if (issue_q == LAST_IDX) issued_all_d = 1'b1;
      end
      if (recv_i) recv_d = recv_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q      <= '0;
      recv_q       <= '0;
      issued_all_q <= 1'b0;
    end else begin
      issue_q      <= issue_d;
      recv_q       <= recv_d;
      issued_all_q <= issued_all_d;
    end
  end

  assign issue_idx_o  = issue_q;
  assign recv_idx_o   = recv_q;
  assign issue_busy_o = !issued_all_q;
  assign last_recv_o  = (recv_q == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one pipelined main memory between I-cache fills,
//               D-cache fills and D-side write-through stores.
// Revision    : 1.0
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  output logic        i_fill_valid,
  output logic [2:0]  i_fill_idx,
  output logic [15:0] i_fill_data,
  output logic        i_fill_done,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  output logic        d_fill_valid,
  output logic [2:0]  d_fill_idx,
  output logic [15:0] d_fill_data,
  output logic        d_fill_done,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        d_wr_ack,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid
);

  arb_state_e       state_q, state_d;
  logic [15:0]      base_q, base_d;
  logic             ctr_clr, issue_go, recv_go;
  logic [CTR_W-1:0] issue_idx, recv_idx;
  logic             issue_busy, last_recv;

  mem_arbiter_block_fill_ctr u_fill_ctr (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (ctr_clr),
    .issue_i      (issue_go),
    .recv_i       (recv_go),
    .issue_idx_o  (issue_idx),
    .recv_idx_o   (recv_idx),
    .issue_busy_o (issue_busy),
    .last_recv_o  (last_recv)
  );

  // Requests are only looked at in IDLE; the grant is held to block end.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    ctr_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_miss) begin
          state_d = ST_D_FILL;
          base_d  = d_miss_addr & BLOCK_MASK;
          ctr_clr = 1'b1;
        end else if (d_wr_req) begin
          state_d = ST_D_WRITE;
        end else if (i_miss) begin
          state_d = ST_I_FILL;
          base_d  = i_miss_addr & BLOCK_MASK;
          ctr_clr = 1'b1;
        end
      end
      ST_D_FILL, ST_I_FILL: begin
        if (recv_go && last_recv) state_d = ST_IDLE;
      end
      ST_D_WRITE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    i_fill_valid = 1'b0;
    i_fill_idx   = '0;
    i_fill_data  = '0;
    i_fill_done  = 1'b0;
    d_fill_valid = 1'b0;
    d_fill_idx   = '0;
    d_fill_data  = '0;
    d_fill_done  = 1'b0;
    d_wr_ack     = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    issue_go     = 1'b0;
    recv_go      = 1'b0;
    case (state_q)
      ST_D_FILL, ST_I_FILL: begin
        if (issue_busy) begin
          mem_en   = 1'b1;
          mem_addr = word_addr(base_q, issue_idx);
          issue_go = 1'b1;
        end
        // Returned words pass straight through to the granted cache.
        if (mem_data_valid) begin
          recv_go = 1'b1;
          if (state_q == ST_D_FILL) begin
            d_fill_valid = 1'b1;
            d_fill_idx   = recv_idx;
            d_fill_data  = mem_rdata;
            d_fill_done  = last_recv;
          end else begin
            i_fill_valid = 1'b1;
            i_fill_idx   = recv_idx;
            i_fill_data  = mem_rdata;
            i_fill_done  = last_recv;
          end
        end
      end
      ST_D_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : pipelined memory model, requester model and scoreboard
//                  around mem_arbiter.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int LAT = 4;
  localparam int BW  = 8;
  localparam logic [1:0] K_NONE = 2'd0, K_DF = 2'd1, K_WR = 2'd2, K_IF = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        i_fill_valid, i_fill_done, d_fill_valid, d_fill_done, d_wr_ack;
  logic [2:0]  i_fill_idx, d_fill_idx;
  logic [15:0] i_fill_data, d_fill_data;
  logic        mem_en, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        inj;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .i_fill_valid(i_fill_valid), .i_fill_idx(i_fill_idx),
    .i_fill_data(i_fill_data), .i_fill_done(i_fill_done),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_fill_valid(d_fill_valid), .d_fill_idx(d_fill_idx),
    .d_fill_data(d_fill_data), .d_fill_done(d_fill_done),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_data_valid(mem_data_valid)
  );

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hA5C3;
  endfunction

  // Memory: a read issued in cycle t returns in cycle t+LAT.
  logic [LAT-1:0] pv;
  logic [15:0]    pa [LAT];
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int k = 0; k < LAT; k++) pa[k] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], mem_en && !mem_wr};
      pa[0] <= mem_addr;
      for (int k = 1; k < LAT; k++) pa[k] <= pa[k-1];
    end
  end
  assign mem_data_valid = pv[LAT-1] | inj;
  assign mem_rdata      = pv[LAT-1] ? memfn(pa[LAT-1]) : (inj ? 16'hDEAD : 16'h0000);

  typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata; } mem_exp_t;
  typedef struct { int cyc; logic side; logic [2:0] idx; logic [15:0] data; logic done; } fill_exp_t;
  typedef struct {
    logic d_miss; logic [15:0] d_miss_addr;
    logic d_wr_req; logic [15:0] d_wr_addr; logic [15:0] d_wr_data;
    logic i_miss; logic [15:0] i_miss_addr;
    logic [5:0] exp_order;
  } vec_t;

  mem_exp_t  mq[$];
  fill_exp_t fq[$];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic logic [76:0] all_outs();
    return {i_fill_valid, i_fill_idx, i_fill_data, i_fill_done,
            d_fill_valid, d_fill_idx, d_fill_data, d_fill_done,
            d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata};
  endfunction

  // One clock; then compare whatever the DUT shows against the scoreboard
  // and let the requesters drop their requests on done/ack.
  task automatic step();
    mem_exp_t    me;
    fill_exp_t   fe;
    logic        side, dn, odn;
    logic [2:0]  idx;
    logic [15:0] dat;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (mem_en) begin
      if (mq.size() == 0) begin
        check(1'b0, "mem_unexpected", $sformatf("cycle %0d got access addr %h wr %b, required none", cyc, mem_addr, mem_wr));
      end else begin
        me = mq.pop_front();
        check(cyc == me.cyc && mem_wr == me.wr && mem_addr == me.addr &&
              (!me.wr || mem_wdata == me.wdata) && d_wr_ack == me.wr, "mem_op",
              $sformatf("got cyc %0d wr %b addr %h wdata %h ack %b, required cyc %0d wr %b addr %h wdata %h ack %b",
                        cyc, mem_wr, mem_addr, mem_wdata, d_wr_ack, me.cyc, me.wr, me.addr, me.wdata, me.wr));
      end
    end else begin
      check(mem_addr == 16'h0 && mem_wdata == 16'h0 && !d_wr_ack, "mem_quiet",
            $sformatf("cycle %0d got addr %h wdata %h ack %b with mem_en=0, required 0 0 0", cyc, mem_addr, mem_wdata, d_wr_ack));
    end
    if (i_fill_valid && d_fill_valid) begin
      check(1'b0, "fill_both", $sformatf("cycle %0d got both fill_valid high, required at most one", cyc));
    end else if (i_fill_valid || d_fill_valid) begin
      side = d_fill_valid;
      idx  = side ? d_fill_idx  : i_fill_idx;
      dat  = side ? d_fill_data : i_fill_data;
      dn   = side ? d_fill_done : i_fill_done;
      odn  = side ? i_fill_done : d_fill_done;
      if (fq.size() == 0) begin
        check(1'b0, "fill_unexpected", $sformatf("cycle %0d got fill side %b idx %0d, required none", cyc, side, idx));
      end else begin
        fe = fq.pop_front();
        check(cyc == fe.cyc && side == fe.side && idx == fe.idx && dat == fe.data && dn == fe.done && !odn, "fill_word",
              $sformatf("got cyc %0d side %b idx %0d data %h done %b other_done %b, required cyc %0d side %b idx %0d data %h done %b other_done 0",
                        cyc, side, idx, dat, dn, odn, fe.cyc, fe.side, fe.idx, fe.data, fe.done));
      end
    end else if (i_fill_done || d_fill_done) begin
      check(1'b0, "done_no_valid", $sformatf("cycle %0d got done i %b d %b without valid, required 0", cyc, i_fill_done, d_fill_done));
    end
    if (i_fill_done) i_miss   = 1'b0;
    if (d_fill_done) d_miss   = 1'b0;
    if (d_wr_ack)    d_wr_req = 1'b0;
  endtask

  task automatic push_service(input logic [1:0] kind, input logic [15:0] addr,
                              input logic [15:0] wdata, input int g, output int g_next);
    logic [15:0] base, a;
    if (kind == K_WR) begin
      mq.push_back('{cyc: g + 1, wr: 1'b1, addr: addr, wdata: wdata});
      g_next = g + 2;
    end else begin
      base = addr & 16'hFFF0;
      for (int k = 0; k < BW; k++) begin
        a = base + 16'(2 * k);
        mq.push_back('{cyc: g + 1 + k, wr: 1'b0, addr: a, wdata: 16'h0});
        fq.push_back('{cyc: g + 1 + LAT + k, side: (kind == K_DF), idx: 3'(k),
                       data: memfn(a), done: (k == BW - 1)});
      end
      g_next = g + BW + LAT + 1;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int         g, gn;
    logic [1:0] kind;
    bit         drained;
    g = cyc;
    d_miss = v.d_miss;     d_miss_addr = v.d_miss_addr;
    d_wr_req = v.d_wr_req; d_wr_addr = v.d_wr_addr; d_wr_data = v.d_wr_data;
    i_miss = v.i_miss;     i_miss_addr = v.i_miss_addr;
    for (int s = 0; s < 3; s++) begin
      kind = v.exp_order[5 - 2 * s -: 2];
      if (kind == K_DF)      push_service(kind, v.d_miss_addr, 16'h0, g, gn);
      else if (kind == K_WR) push_service(kind, v.d_wr_addr, v.d_wr_data, g, gn);
      else if (kind == K_IF) push_service(kind, v.i_miss_addr, 16'h0, g, gn);
      else gn = g;
      g = gn;
    end
    drained = 1'b0;
    for (int n = 0; n < 300 && !drained; n++) begin
      step();
      drained = (mq.size() == 0 && fq.size() == 0 && !d_miss && !d_wr_req && !i_miss);
    end
    if (!drained) begin
      check(1'b0, "timeout", $sformatf("%s: %0d mem ops and %0d words outstanding after 300 cycles, required 0",
                                       name, mq.size(), fq.size()));
      mq.delete(); fq.delete();
      d_miss = 1'b0; d_wr_req = 1'b0; i_miss = 1'b0;
    end
    repeat (3) step();
  endtask

  function automatic vec_t mkvec(input logic dm, input logic [15:0] dma, input logic dw,
                                 input logic [15:0] dwa, input logic [15:0] dwd,
                                 input logic im, input logic [15:0] ima, input logic [5:0] ord);
    vec_t v;
    v.d_miss = dm;   v.d_miss_addr = dma;
    v.d_wr_req = dw; v.d_wr_addr = dwa; v.d_wr_data = dwd;
    v.i_miss = im;   v.i_miss_addr = ima;
    v.exp_order = ord;
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    int c0, gn;
    rst = 1'b1; inj = 1'b0;
    i_miss = 1'b0; i_miss_addr = '0;
    d_miss = 1'b0; d_miss_addr = '0;
    d_wr_req = 1'b0; d_wr_addr = '0; d_wr_data = '0;

    vecs[0] = mkvec(0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h1234, {K_IF, K_NONE, K_NONE});
    vecs[1] = mkvec(1, 16'h00A6, 0, 16'h0000, 16'h0000, 1, 16'h2000, {K_DF, K_IF, K_NONE});
    vecs[2] = mkvec(0, 16'h0000, 1, 16'h0040, 16'hBEEF, 0, 16'h0000, {K_WR, K_NONE, K_NONE});
    vecs[3] = mkvec(0, 16'h0000, 1, 16'h0041, 16'h1234, 1, 16'h3008, {K_WR, K_IF, K_NONE});
    vecs[4] = mkvec(1, 16'h0F1E, 1, 16'h0102, 16'hCAFE, 1, 16'hFFFE, {K_DF, K_WR, K_IF});
    vecs[5] = mkvec(1, 16'hFFFF, 0, 16'h0000, 16'h0000, 0, 16'h0000, {K_DF, K_NONE, K_NONE});
    vecs[6] = mkvec(1, 16'h0010, 1, 16'h0020, 16'h5555, 0, 16'h0000, {K_DF, K_WR, K_NONE});

    repeat (3) step();
    check(all_outs() == '0, "reset_state", $sformatf("got outputs %h, required 0", all_outs()));
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of an I fill: everything quiet next cycle.
    c0 = cyc;
    i_miss = 1'b1; i_miss_addr = 16'h1234;
    push_service(K_IF, 16'h1234, 16'h0, c0, gn);
    repeat (6) step();
    rst = 1'b1;
    step();
    check(all_outs() == '0, "rst_abort", $sformatf("cycle %0d got outputs %h, required 0", cyc, all_outs()));
    mq.delete(); fq.delete();
    i_miss = 1'b0;
    rst = 1'b0;
    repeat (2) step();
    run_vec(vecs[0], "after_rst");

    // Stray memory data while idle must not reach either cache.
    inj = 1'b1;
    #1;
    check(!i_fill_valid && !d_fill_valid && !i_fill_done && !d_fill_done, "stray_valid",
          $sformatf("got i_valid %b d_valid %b i_done %b d_done %b, required all 0",
                    i_fill_valid, d_fill_valid, i_fill_done, d_fill_done));
    step();
    inj = 1'b0;
    step();
    run_vec(vecs[1], "after_stray");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
